// File: rtl/ptmch_trg_mc.sv
// ptmch_trg_mc: SPI-programmed multi-channel trigger pulse generator.
// An SPI slave (sampled in the CLK200M domain) writes per-channel delay,
// width and repeat registers, and issues fire/abort commands that start or
// stop timed pulse trains on the TRG_PLS outputs.
`timescale 1ns/1ps
module ptmch_trg_mc #(
    parameter int N_CH        = 3,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            CLK200M,
    input  logic            RESET,
    input  logic            SPI_CS,
    input  logic            SPI_CLK,
    input  logic            SPI_MOSI,
    output logic [N_CH-1:0] TRG_PLS,
    output logic [N_CH-1:0] TRG_BUSY,
    output logic            FRM_ERR
);

    // Channel FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DLY  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Frame opcodes
    localparam logic [1:0] OP_DLY = 2'b00;
    localparam logic [1:0] OP_WID = 2'b01;
    localparam logic [1:0] OP_CMD = 2'b10;
    localparam logic [1:0] OP_REP = 2'b11;

    localparam logic [4:0] BITS_FRAME = 5'd24;
    localparam logic [4:0] BITS_SAT   = 5'd25;

    // ------------------------------------------------------------------
    // SPI input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_sclk_d;
    logic                   w_cs;
    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sclk_rise;

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;
    assign w_sclk_rise = ~r_sclk_d & w_sclk;

    // Bring the asynchronous SPI pins into CLK200M and keep one cycle of history for edges
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, so the chain really has SYNC_STAGES stages.
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], SPI_CS};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            r_cs_d      <= w_cs;
            r_sclk_d    <= w_sclk;
        end
    end

    // ------------------------------------------------------------------
    // Frame shifter, length check and commit strobe
    // ------------------------------------------------------------------
    logic [23:0] r_shift;
    logic [23:0] r_frame;
    logic [4:0]  r_bit_cnt;
    logic        r_commit;
    logic        r_frm_err;

    // Shift MOSI on SPI clock rises; judge the frame length when CS rises
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            r_shift   <= '0;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_commit  <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            if (w_cs_fall) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise && !w_cs) begin
                r_shift <= {r_shift[22:0], w_mosi};
                if (r_bit_cnt != BITS_SAT) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
            r_commit  <= w_cs_rise && (r_bit_cnt == BITS_FRAME);
            r_frm_err <= w_cs_rise && (r_bit_cnt != BITS_FRAME);
            if (w_cs_rise) begin
                r_frame <= r_shift;
            end
        end
    end

    assign FRM_ERR = r_frm_err;

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    logic [1:0]       w_op;
    logic [5:0]       w_ch;
    logic [15:0]      w_val;
    logic [CNT_W-1:0] w_val_c;
    logic             w_ch_ok;
    logic             w_wr_dly;
    logic             w_wr_wid;
    logic             w_wr_rep;
    logic [N_CH-1:0]  w_fire_mask;
    logic [N_CH-1:0]  w_abort_mask;

    assign w_val_c = w_val[CNT_W-1:0];

    // Turn a committed frame into register write enables and fire/abort masks
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        w_op         = r_frame[23:22];
        w_ch         = r_frame[21:16];
        w_val        = r_frame[15:0];
        w_ch_ok      = (w_ch < 6'(N_CH));
        w_wr_dly     = r_commit && (w_op == OP_DLY) && w_ch_ok;
        w_wr_wid     = r_commit && (w_op == OP_WID) && w_ch_ok;
        w_wr_rep     = r_commit && (w_op == OP_REP) && w_ch_ok;
        w_fire_mask  = '0;
        w_abort_mask = '0;
        if (r_commit && (w_op == OP_CMD)) begin
            if (w_val[15]) begin
                w_abort_mask = w_val[N_CH-1:0];
            end else begin
                w_fire_mask = w_val[N_CH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel configuration registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_delay [N_CH];
    logic [CNT_W-1:0] r_width [N_CH];
    logic [CNT_W-1:0] r_rep   [N_CH];

    // Apply delay/width/repeat writes; a width of 0 is stored as 1
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            // NOTE: these small flop arrays are reset on purpose; the defaults are visible behaviour, unlike a RAM.
            for (int i = 0; i < N_CH; i++) begin
                r_delay[i] <= '0;
                r_width[i] <= CNT_W'(1);
                r_rep[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_ch == 6'(i)) begin
                    if (w_wr_dly) begin
                        r_delay[i] <= w_val_c;
                    end
                    if (w_wr_wid) begin
                        r_width[i] <= (w_val_c == '0) ? CNT_W'(1) : w_val_c;
                    end
                    if (w_wr_rep) begin
                        r_rep[i] <= w_val_c;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel pulse train FSMs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] r_wm1;
        logic [CNT_W-1:0] w_wm1_nxt;
        logic [CNT_W-1:0] r_left;
        logic [CNT_W-1:0] w_left_nxt;
        logic             r_pls;
        logic             r_busy;

        // Advance the train first, then let abort/fire act on the result, so a
        // fire landing on the final HIGH cycle restarts the channel
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_wm1_nxt   = r_wm1;
            w_left_nxt  = r_left;
            case (r_state)
                S_DLY: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = r_wm1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        if (r_left != '0) begin
                            w_state_nxt = S_GAP;
                            w_cnt_nxt   = r_wm1;
                            w_left_nxt  = r_left - CNT_W'(1);
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = r_wm1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
            if (w_abort_mask[g]) begin
                w_state_nxt = S_IDLE;
            end else if (w_fire_mask[g] && (w_state_nxt == S_IDLE)) begin
                w_state_nxt = S_DLY;
                w_cnt_nxt   = r_delay[g];
                w_wm1_nxt   = r_width[g] - CNT_W'(1);
                w_left_nxt  = r_rep[g];
            end
        end

        // Register the channel state and decode outputs from the next state so they are glitch-free flops
        always_ff @(posedge CLK200M or posedge RESET) begin
            if (RESET) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_wm1   <= '0;
                r_left  <= '0;
                r_pls   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_wm1   <= w_wm1_nxt;
                r_left  <= w_left_nxt;
                r_pls   <= (w_state_nxt == S_HIGH);
                r_busy  <= (w_state_nxt != S_IDLE);
            end
        end

        assign TRG_PLS[g]  = r_pls;
        assign TRG_BUSY[g] = r_busy;
    end

endmodule
